alu_share_ctrl: RTL and testbench

Two-port arbiter and sequencer that shares a single 32-bit ALU (3-bit control code, 32-bit result, 2-bit status {N,Z}) between two requesters, e.g. the main datapath and an address/branch-compare unit. It sits between the requesters and the ALU instance. Requests are granted round-robin, and operands and control are registered toward the ALU. The result and status are captured into a response register that is held until the consumer accepts it. At most one operation is in flight.

---
 rtl/alu_share_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Optional macro ALU_SHARE_OPCHECK_EN: undefined opcodes 3'b100/3'b101 yield a zeroed, error-flagged response.
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_gin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_gin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_gin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic [1:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic [1:0]       rsp_status,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_q;
  logic               grant0, grant1, accept;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [2:0]         gin_sel, gin_fwd;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [2:0]         alu_gin_q;
  logic               rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic [1:0]         rsp_status_q;

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q == 1 means requester 1 won the previous grant, so 0 wins a tie
        if (req0_valid && (!req1_valid || last_q)) grant0 = 1'b1;
        else if (req1_valid)                       grant1 = 1'b1;
        if (grant0 || grant1) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept     = (grant0 || grant1) && !reset;
  assign req0_ready = grant0 && !reset;
  assign req1_ready = grant1 && !reset;

  assign a_sel   = grant1 ? req1_a   : req0_a;
  assign b_sel   = grant1 ? req1_b   : req0_b;
  assign gin_sel = grant1 ? req1_gin : req0_gin;

`ifdef ALU_SHARE_OPCHECK_EN
  logic illegal;
  logic bad_q;
  logic rsp_err_q;

  assign illegal = (gin_sel[2:1] == 2'b10);
  assign gin_fwd = illegal ? 3'b000 : gin_sel;
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept)            bad_q     <= illegal;
      if (state_q == EXEC)   rsp_err_q <= bad_q;
    end
  end
`else
  assign gin_fwd = gin_sel;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_gin_q    <= 3'b000;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q   <= a_sel;
        alu_b_q   <= b_sel;
        alu_gin_q <= gin_fwd;
        last_q    <= grant1;
        rsp_id_q  <= grant1;
      end
      // Capture the ALU output at the end of the evaluation cycle
      if (state_q == EXEC) begin
`ifdef ALU_SHARE_OPCHECK_EN
        rsp_sum_q    <= bad_q ? '0    : alu_sum;
        rsp_status_q <= bad_q ? 2'b01 : alu_status;
`else
        rsp_sum_q    <= alu_sum;
        rsp_status_q <= alu_status;
`endif
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_gin    = alu_gin_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = (state_q == IDLE) ? 1'b0 : rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU.
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_gin, req1_gin;
  logic [W-1:0] alu_a, alu_b, alu_sum;
  logic [2:0]   alu_gin;
  logic [1:0]   alu_status;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_sum;
  logic [1:0]   rsp_status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_gin(req0_gin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_gin(req1_gin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
    .alu_sum(alu_sum), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_status(rsp_status), .rsp_err(rsp_err)
  );

  // Behavioural ALU: AND, OR, ADD, SUB, SLT; undefined codes return a marker value
  always_comb begin
    alu_sum = 32'hDEADBEEF;
    case (alu_gin)
      3'b000: alu_sum = alu_a & alu_b;
      3'b001: alu_sum = alu_a | alu_b;
      3'b010: alu_sum = alu_a + alu_b;
      3'b110: alu_sum = alu_a - alu_b;
      3'b111: alu_sum = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_sum = 32'hDEADBEEF;
    endcase
  end
  assign alu_status = {alu_sum[W-1], (alu_sum == '0)};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Single-requester transaction with rsp_ready raised once the response appears
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] gin, input logic [2:0] exp_gin,
                        input logic [31:0] exp_sum, input logic [1:0] exp_st,
                        input bit exp_err);
    if (sel) begin
      req1_a = a; req1_b = b; req1_gin = gin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_gin = gin; req0_valid = 1'b1;
    end
    #1;
    check_eq("op_ready", sel ? req1_ready : req0_ready, 1);
    check_eq("op_other_ready", sel ? req0_ready : req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("op_alu_a", alu_a, a);
    check_eq("op_alu_gin", alu_gin, exp_gin);
    check_eq("op_exec_rsp_valid", rsp_valid, 0);
    step();
    check_eq("op_rsp_valid", rsp_valid, 1);
    check_eq("op_rsp_sum", rsp_sum, exp_sum);
    check_eq("op_rsp_status", rsp_status, exp_st);
    check_eq("op_rsp_id", rsp_id, sel);
    check_eq("op_rsp_err", rsp_err, exp_err);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("op_idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_gin = 3'b000;
    req1_a = '0; req1_b = '0; req1_gin = 3'b000;
    step();
    step();
    check_eq("rst_req0_ready", req0_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_gin", alu_gin, 0);
    check_eq("rst_rsp_sum", rsp_sum, 0);
    check_eq("rst_rsp_status", rsp_status, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single add from requester 0
    run_op(1'b0, 32'd5, 32'd3, 3'b010, 3'b010, 32'd8, 2'b00, 1'b0);

    // Tie after reset: req0 first, then req1, then req0 again
    do_reset();
    req0_a = 32'd3;   req0_b = 32'd5;   req0_gin = 3'b110; req0_valid = 1'b1;
    req1_a = 32'hF0;  req1_b = 32'h3C;  req1_gin = 3'b000; req1_valid = 1'b1;
    #1;
    check_eq("tie1_r0_ready", req0_ready, 1);
    check_eq("tie1_r1_ready", req1_ready, 0);
    step();
    check_eq("exec_r0_ready", req0_ready, 0);
    check_eq("exec_r1_ready", req1_ready, 0);
    check_eq("tie1_alu_gin", alu_gin, 3'b110);
    step();
    check_eq("tie1_rsp_sum", rsp_sum, 32'hFFFFFFFE);
    check_eq("tie1_rsp_status", rsp_status, 2'b10);
    check_eq("tie1_rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("tie2_rsp_valid", rsp_valid, 0);
    check_eq("tie2_r1_ready", req1_ready, 1);
    check_eq("tie2_r0_ready", req0_ready, 0);
    step();
    check_eq("tie2_alu_gin", alu_gin, 3'b000);
    check_eq("tie2_alu_a", alu_a, 32'hF0);
    step();
    check_eq("tie2_rsp_sum", rsp_sum, 32'h30);
    check_eq("tie2_rsp_status", rsp_status, 2'b00);
    check_eq("tie2_rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("tie3_r0_ready", req0_ready, 1);
    check_eq("tie3_r1_ready", req1_ready, 0);

    // Backpressure: hold RESP for 10 cycles with req1 waiting
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_rsp_valid", rsp_valid, 1);
      check_eq("bp_rsp_sum", rsp_sum, 32'hFFFFFFFE);
      check_eq("bp_r0_ready", req0_ready, 0);
      check_eq("bp_r1_ready", req1_ready, 0);
      check_eq("bp_alu_gin", alu_gin, 3'b110);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("bp_release_rsp_valid", rsp_valid, 0);
    check_eq("bp_release_r1_ready", req1_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("bp_next_alu_gin", alu_gin, 3'b000);
    step();
    check_eq("bp_next_rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Compare and zero paths from requester 1
    run_op(1'b1, 32'd2, 32'd7, 3'b111, 3'b111, 32'd1, 2'b00, 1'b0);
    run_op(1'b1, 32'd9, 32'd9, 3'b110, 3'b110, 32'd0, 2'b01, 1'b0);

    // Reset during EXEC drops the op and restores the tie pointer
    req0_a = 32'd1; req0_b = 32'd1; req0_gin = 3'b010; req0_valid = 1'b1;
    req1_a = 32'd4; req1_b = 32'd4; req1_gin = 3'b010; req1_valid = 1'b1;
    #1;
    check_eq("mr_r0_ready", req0_ready, 1);
    step();
    check_eq("mr_alu_a", alu_a, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mr_rst_r0_ready", req0_ready, 0);
    check_eq("mr_rst_r1_ready", req1_ready, 0);
    step();
    check_eq("mr_rsp_valid", rsp_valid, 0);
    check_eq("mr_alu_a_rst", alu_a, 0);
    check_eq("mr_alu_gin_rst", alu_gin, 0);
    check_eq("mr_rsp_sum_rst", rsp_sum, 0);
    reset = 1'b0;
    #1;
    check_eq("mr_tie_r0_ready", req0_ready, 1);
    check_eq("mr_tie_r1_ready", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check_eq("mr_rsp_sum", rsp_sum, 32'd2);
    check_eq("mr_rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Undefined opcode
`ifdef ALU_SHARE_OPCHECK_EN
    run_op(1'b0, 32'd7, 32'd9, 3'b100, 3'b000, 32'd0, 2'b01, 1'b1);
`else
    run_op(1'b0, 32'd7, 32'd9, 3'b100, 3'b100, 32'hDEADBEEF, 2'b10, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
